// File: rtl/reaction_game_pkg.sv
// Shared types, segment codes and helpers for the reaction game controller.
package reaction_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNTDOWN,
    ST_WAIT_GO,
    ST_MEASURE,
    ST_RESULT,
    ST_DISQUAL
  } state_e;

  // Four BCD digits, index 0 is the least-significant digit.
  typedef logic [3:0][3:0] bcd_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_I     = 7'h7B;
  localparam logic [6:0] SEG_S     = 7'h12;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Decimal digit to segment code; anything above 9 shows blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // Ripple-carry BCD increment; 9999 wraps to 0000 (callers saturate first).
  function automatic bcd_t bcd_inc(input bcd_t b);
    bcd_t r;
    logic carry;
    r     = b;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (b[i] == 4'd9) begin
          r[i] = 4'd0;
        end else begin
          r[i]  = b[i] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // BCD count to binary milliseconds.
  function automatic logic [13:0] bcd_to_bin(input bcd_t b);
    return 14'(b[3]) * 14'd1000 + 14'(b[2]) * 14'd100 +
           14'(b[1]) * 14'd10   + 14'(b[0]);
  endfunction

endpackage

// File: rtl/reaction_game_press_detect.sv
// Player button conditioning: 2-flop synchronizer, falling-edge detect and
// a re-trigger lockout counted in ms_ticks after each accepted press.
module reaction_game_press_detect
  import reaction_game_pkg::*;
#(
  parameter int unsigned LOCKOUT_MS = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ms_tick,
  input  logic key_n,
  output logic press
);

  localparam int unsigned LW = $clog2(LOCKOUT_MS + 2);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_MS);

  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d;
  logic [LW-1:0] lock_q, lock_d;
  logic          fall;

  // Synchronized high-to-low transition, qualified by the lockout.
  assign fall  = prev_q & ~sync_q[1];
  assign press = fall & (lock_q == '0);

  // Next-state: shift the pin in, remember the last synced level, run lockout.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    sync_d = {sync_q[0], key_n};
    prev_d = sync_q[1];
    lock_d = lock_q;
    if (press) begin
      lock_d = LOCK_LOAD;
    end else if (ms_tick && (lock_q != '0)) begin
      lock_d = lock_q - LW'(1);
    end
  end

  // State registers; released button level is the reset value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only.
    if (!reset_n) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      lock_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      lock_q <= lock_d;
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game: countdown, random hold-off, timed reaction in BCD ms,
// 4-digit 7-segment display with registered outputs.
module reaction_game_ctrl
  import reaction_game_pkg::*;
#(
  parameter int unsigned COUNTDOWN_MS  = 3000,
  parameter int unsigned DELAY_BASE_MS = 1000,
  parameter int unsigned LOCKOUT_MS    = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ms_tick,
  input  logic        start,
  input  logic        key_n,
  output logic        go_led,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic        result_valid,
  output logic [13:0] result_ms
);

  localparam logic [3:0]  CD_SECS    = 4'(COUNTDOWN_MS / 1000);
  localparam logic [15:0] DELAY_BASE = 16'(DELAY_BASE_MS);

  state_e           state_q, state_d;
  logic [15:0]      ms_cnt_q, ms_cnt_d;
  logic [3:0]       sec_q, sec_d;
  logic [15:0]      hold_q, hold_d;
  bcd_t             bcd_q, bcd_d;
  bcd_t             bcd_nxt;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             go_led_q, go_led_d;
  logic             result_valid_q, result_valid_d;
  logic [13:0]      result_ms_q, result_ms_d;
  logic [3:0][6:0]  hex_q, hex_d;
  logic             press;

  reaction_game_press_detect #(
    .LOCKOUT_MS(LOCKOUT_MS)
  ) u_press (
    .clk     (clk),
    .reset_n (reset_n),
    .ms_tick (ms_tick),
    .key_n   (key_n),
    .press   (press)
  );

  assign bcd_nxt = bcd_inc(bcd_q);
  assign lfsr_d  = lfsr_next(lfsr_q);

  // Round sequencing. A press always wins over a same-cycle tick, so the
  // count freezes at its pre-tick value and a press at hold-off expiry
  // disqualifies.
  always_comb begin
    state_d  = state_q;
    ms_cnt_d = ms_cnt_q;
    sec_d    = sec_q;
    hold_d   = hold_q;
    bcd_d    = bcd_q;
    case (state_q)
      ST_IDLE, ST_RESULT, ST_DISQUAL: begin
        if (start) begin
          state_d  = ST_COUNTDOWN;
          ms_cnt_d = '0;
          sec_d    = CD_SECS;
        end
      end
      ST_COUNTDOWN: begin
        if (press) begin
          state_d = ST_DISQUAL;
        end else if (ms_tick) begin
          if (ms_cnt_q == 16'd999) begin
            ms_cnt_d = '0;
            if (sec_q <= 4'd1) begin
              state_d = ST_WAIT_GO;
              hold_d  = DELAY_BASE + 16'(lfsr_q[9:0]);
            end else begin
              sec_d = sec_q - 4'd1;
            end
          end else begin
            ms_cnt_d = ms_cnt_q + 16'd1;
          end
        end
      end
      ST_WAIT_GO: begin
        if (press) begin
          state_d = ST_DISQUAL;
        end else if (ms_tick) begin
          if ((ms_cnt_q + 16'd1) >= hold_q) begin
            state_d  = ST_MEASURE;
            ms_cnt_d = '0;
            bcd_d    = '0;
          end else begin
            ms_cnt_d = ms_cnt_q + 16'd1;
          end
        end
      end
      ST_MEASURE: begin
        if (press) begin
          state_d = ST_RESULT;
        end else if (ms_tick) begin
          bcd_d = bcd_nxt;
          if (bcd_nxt == 16'h9999) begin
            state_d = ST_RESULT;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the current state/count; registered below.
  always_comb begin
    hex_d = {4{SEG_BLANK}};
    case (state_q)
      ST_IDLE:      hex_d = {4{SEG_DASH}};
      ST_COUNTDOWN: hex_d[0] = seg_digit(sec_q);
      ST_MEASURE, ST_RESULT: begin
        for (int i = 0; i < 4; i++) begin
          hex_d[i] = seg_digit(bcd_q[i]);
        end
      end
      ST_DISQUAL: begin
        hex_d[2] = SEG_D;
        hex_d[1] = SEG_I;
        hex_d[0] = SEG_S;
      end
      default: hex_d = {4{SEG_BLANK}};
    endcase
    go_led_d       = (state_q == ST_MEASURE);
    result_valid_d = (state_q == ST_RESULT);
    result_ms_d    = (state_q == ST_RESULT) ? bcd_to_bin(bcd_q) : result_ms_q;
  end

  // All state, LFSR and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      ms_cnt_q       <= '0;
      sec_q          <= '0;
      hold_q         <= '0;
      bcd_q          <= '0;
      lfsr_q         <= LFSR_SEED;
      go_led_q       <= 1'b0;
      result_valid_q <= 1'b0;
      result_ms_q    <= '0;
      hex_q          <= {4{SEG_BLANK}};
    end else begin
      state_q        <= state_d;
      ms_cnt_q       <= ms_cnt_d;
      sec_q          <= sec_d;
      hold_q         <= hold_d;
      bcd_q          <= bcd_d;
      lfsr_q         <= lfsr_d;
      go_led_q       <= go_led_d;
      result_valid_q <= result_valid_d;
      result_ms_q    <= result_ms_d;
      hex_q          <= hex_d;
    end
  end

  assign go_led       = go_led_q;
  assign result_valid = result_valid_q;
  assign result_ms    = result_ms_q;
  assign hex0         = hex_q[0];
  assign hex1         = hex_q[1];
  assign hex2         = hex_q[2];
  assign hex3         = hex_q[3];

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl: table of timed rounds, hand
// sequences for lockout, coincident events and reset, and randomized rounds
// predicted from a timeline model of the game.
module tb_reaction_game_ctrl;

  localparam int CD_MS   = 3000;
  localparam int BASE_MS = 100;
  localparam int LOCK_MS = 20;

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] DA = 7'h3F;

  logic        clk = 1'b0;
  logic        reset_n, ms_tick, start, key_n;
  logic        go_led, result_valid;
  logic [6:0]  hex0, hex1, hex2, hex3;
  logic [13:0] result_ms;
  logic [15:0] m_lfsr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    int          press_at;   // ms_ticks after go_led rises (or tick budget)
    int          mode;       // 0 plain, 1 bounce, 2 press with tick, 3 no press
    int          exp_ms;
    logic [27:0] exp_hex;    // {hex3,hex2,hex1,hex0}
  } vec_t;

  always #10 clk = ~clk;

  reaction_game_ctrl #(
    .COUNTDOWN_MS  (CD_MS),
    .DELAY_BASE_MS (BASE_MS),
    .LOCKOUT_MS    (LOCK_MS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ms_tick      (ms_tick),
    .start        (start),
    .key_n        (key_n),
    .go_led       (go_led),
    .hex0         (hex0),
    .hex1         (hex1),
    .hex2         (hex2),
    .hex3         (hex3),
    .result_valid (result_valid),
    .result_ms    (result_ms)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return (v >> 1) | (16'(fb) << 15);
  endfunction

  // Free-running reference LFSR, aligned with the design's generator.
  always @(posedge clk) m_lfsr <= (!reset_n) ? 16'hACE1 : lfsr_step(m_lfsr);

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return BL;
    endcase
  endfunction

  function automatic logic [27:0] dec_hex(input int v);
    return {seg(v / 1000), seg((v / 100) % 10), seg((v / 10) % 10), seg(v % 10)};
  endfunction

  function automatic logic [27:0] get_hex();
    return {hex3, hex2, hex1, hex0};
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_step(input logic t);
    ms_tick = t;
    @(posedge clk);
    #1;
    ms_tick = 1'b0;
  endtask

  task automatic ms(input int n);
    for (int i = 0; i < n; i++) begin
      clk_step(1'b1);
      clk_step(1'b0);
    end
  endtask

  task automatic press_idle();
    key_n = 1'b0;
    repeat (4) clk_step(1'b0);
  endtask

  task automatic release_key();
    key_n = 1'b1;
    ms(LOCK_MS + 5);
  endtask

  task automatic do_start();
    start = 1'b1;
    clk_step(1'b0);
    start = 1'b0;
    clk_step(1'b0);
    check("countdown_hex_3", get_hex(), {BL, BL, BL, seg(3)});
    check("countdown_go_led", go_led, 0);
  endtask

  // Runs the whole countdown; h is the hold-off the design must load.
  task automatic run_countdown(output int h);
    ms(CD_MS - 1);
    h = BASE_MS + int'(m_lfsr[9:0]);
    ms(1);
    check("wait_go_blank", get_hex(), {BL, BL, BL, BL});
    check("wait_go_led", go_led, 0);
  endtask

  task automatic wait_go(input int h);
    int n;
    n = 0;
    while (go_led !== 1'b1 && n < 2200) begin
      ms(1);
      n++;
    end
    check("holdoff_ticks", n, h);
    check("measure_hex_0000", get_hex(), dec_hex(0));
  endtask

  task automatic expect_disqual(input string name);
    check({name, "_hex"}, get_hex(), {BL, 7'h21, 7'h7B, 7'h12});
    check({name, "_go_led"}, go_led, 0);
    check({name, "_valid"}, result_valid, 0);
  endtask

  task automatic expect_result(input string name, input int v, input logic [27:0] hx);
    check({name, "_valid"}, result_valid, 1);
    check({name, "_ms"}, result_ms, v);
    check({name, "_go_led"}, go_led, 0);
    check({name, "_hex"}, get_hex(), hx);
  endtask

  // Timeline model: press lands k ticks after start, outcome from the rules.
  task automatic random_round(input int k);
    int h, rem;
    do_start();
    if (k < CD_MS) begin
      ms(k);
      press_idle();
      expect_disqual("rnd_countdown");
    end else begin
      run_countdown(h);
      rem = k - CD_MS;
      ms(rem);
      press_idle();
      if (rem < h) expect_disqual("rnd_wait_go");
      else         expect_result("rnd_measure", rem - h, dec_hex(rem - h));
    end
    release_key();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[4];
    int   h;

    vecs[0] = '{"normal_250",  250,  0, 250,  {7'h40, 7'h24, 7'h12, 7'h40}};
    vecs[1] = '{"bounce_40",   40,   1, 40,   {7'h40, 7'h40, 7'h19, 7'h40}};
    vecs[2] = '{"tick_at_99",  99,   2, 99,   {7'h40, 7'h40, 7'h10, 7'h10}};
    vecs[3] = '{"no_press",    9999, 3, 9999, {7'h10, 7'h10, 7'h10, 7'h10}};

    reset_n = 1'b0;
    ms_tick = 1'b0;
    start   = 1'b0;
    key_n   = 1'b1;
    repeat (3) clk_step(1'b0);
    check("rst_go_led", go_led, 0);
    check("rst_valid", result_valid, 0);
    check("rst_ms", result_ms, 0);
    check("rst_hex", get_hex(), {BL, BL, BL, BL});
    reset_n = 1'b1;
    repeat (2) clk_step(1'b0);
    check("idle_dashes", get_hex(), {DA, DA, DA, DA});

    // Press in IDLE arms the lockout; a second press 3 ms into the
    // countdown falls inside it and must not disqualify.
    key_n = 1'b0;
    repeat (3) clk_step(1'b0);
    ms(2);
    key_n = 1'b1;
    ms(2);
    do_start();
    ms(3);
    press_idle();
    check("lockout_suppressed", get_hex(), {BL, BL, BL, seg(3)});
    key_n = 1'b1;
    ms(30);
    ms(967);
    check("countdown_hex_2", get_hex(), {BL, BL, BL, seg(2)});
    ms(200);
    press_idle();
    expect_disqual("early_1200");
    release_key();

    for (int i = 0; i < 4; i++) begin
      int n;
      do_start();
      run_countdown(h);
      wait_go(h);
      case (vecs[i].mode)
        0: begin
          ms(vecs[i].press_at);
          press_idle();
        end
        1: begin
          ms(vecs[i].press_at);
          key_n = 1'b0; clk_step(1'b0);
          key_n = 1'b1; clk_step(1'b0);
          key_n = 1'b0; clk_step(1'b0);
          key_n = 1'b1; clk_step(1'b0);
          key_n = 1'b0; clk_step(1'b0);
          repeat (2) clk_step(1'b0);
        end
        2: begin
          ms(vecs[i].press_at);
          key_n = 1'b0;
          clk_step(1'b0);
          clk_step(1'b0);
          clk_step(1'b1);
          repeat (2) clk_step(1'b0);
        end
        default: begin
          n = 0;
          while (result_valid !== 1'b1 && n < 10100) begin
            ms(1);
            n++;
          end
          check({vecs[i].name, "_ticks"}, n, vecs[i].press_at);
        end
      endcase
      expect_result(vecs[i].name, vecs[i].exp_ms, vecs[i].exp_hex);
      release_key();
    end

    // Press event lands on the final hold-off tick.
    do_start();
    run_countdown(h);
    ms(h - 1);
    key_n = 1'b0;
    clk_step(1'b0);
    clk_step(1'b0);
    clk_step(1'b1);
    repeat (2) clk_step(1'b0);
    expect_disqual("press_at_holdoff");
    release_key();

    repeat (2) random_round(int'($urandom_range(CD_MS + 1300, 0)));

    // Reset in the middle of a timed reaction.
    do_start();
    run_countdown(h);
    wait_go(h);
    ms(10);
    check("mid_measure_go_led", go_led, 1);
    reset_n = 1'b0;
    clk_step(1'b0);
    check("midrst_go_led", go_led, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_ms", result_ms, 0);
    check("midrst_hex", get_hex(), {BL, BL, BL, BL});
    reset_n = 1'b1;
    repeat (2) clk_step(1'b0);
    check("midrst_idle_dashes", get_hex(), {DA, DA, DA, DA});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
